// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: round-robin arbiter that places NUM_REQ requesters onto a
// single synchronous data-memory port. It registers the grant and the DM bus,
// supports a forced-owner override (force_en/force_sel), and returns tagged
// read data one cycle after a read is issued.
// Optional feature macro: DM_ARB_LOCK_EN adds req_lock and locked bus ownership.
module dm_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_wr_en,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef DM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  input  logic                      force_en,
  input  logic [ID_W-1:0]           force_sel,
  input  logic [DATA_W-1:0]         DM_data_out,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         DM_data_in,
  output logic [ADDR_W-1:0]         DM_addr,
  output logic                      DM_write_en,
  output logic                      rd_valid,
  output logic [ID_W-1:0]           rd_id,
  output logic [DATA_W-1:0]         rd_data
);

  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [DATA_W-1:0]  data_arr [NUM_REQ];
  logic [NUM_REQ-1:0] force_mask;
  logic [NUM_REQ-1:0] elig;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    rr_next;
  logic [ID_W-1:0]    win_id;
  logic               win_found;
  logic [ID_W:0]      scan_idx;
  logic [ID_W-1:0]    gnt_id;
  logic               rd_issue;

`ifdef DM_ARB_LOCK_EN
  logic               owner_valid;
  logic [ID_W-1:0]    owner_id;
`endif

  // Unpack the per-requester address/data fields
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Forced-owner mask; an out-of-range force_sel shifts out and masks everyone
  always_comb begin
    force_mask = '1;
    if (force_en) begin
      force_mask = NUM_REQ'(1) << force_sel;
    end
  end

  // Eligible set: requesters granted this cycle sit out the next edge
  always_comb begin
    elig = req & ~gnt;
`ifdef DM_ARB_LOCK_EN
    // The lock owner bypasses the ~gnt mask and excludes everybody else
    if (owner_valid && !force_en) begin
      elig           = '0;
      elig[owner_id] = req[owner_id];
    end
`endif
    elig = elig & force_mask;
  end

  // Round-robin search starting at rr_ptr, wrapping at NUM_REQ
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
      end
      if (!win_found && elig[scan_idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = scan_idx[ID_W-1:0];
      end
    end
  end

  // Pointer just past the winner, modulo NUM_REQ
  always_comb begin
    rr_next = win_id + ID_W'(1);
    if (win_id == ID_W'(NUM_REQ - 1)) begin
      rr_next = '0;
    end
  end

  // Registered grant and DM bus; address/data hold when nothing is granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt         <= '0;
      gnt_id      <= '0;
      DM_addr     <= '0;
      DM_data_in  <= '0;
      DM_write_en <= 1'b0;
      rr_ptr      <= '0;
    end else if (win_found) begin
      gnt         <= NUM_REQ'(1) << win_id;
      gnt_id      <= win_id;
      DM_addr     <= addr_arr[win_id];
      DM_data_in  <= data_arr[win_id];
      DM_write_en <= req_wr_en[win_id];
      if (!force_en) begin
        rr_ptr <= rr_next;
      end
    end else begin
      gnt         <= '0;
      DM_write_en <= 1'b0;
    end
  end

  assign rd_issue = (|gnt) & ~DM_write_en;

  // Read return: the read on the bus this cycle is reported after the next edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_id    <= '0;
    end else begin
      rd_valid <= rd_issue;
      if (rd_issue) begin
        rd_id <= gnt_id;
      end
    end
  end

  // The synchronous DM already registers its output, so rd_data is a plain pass
  always_comb begin
    rd_data = '0;
    if (rd_valid) begin
      rd_data = DM_data_out;
    end
  end

`ifdef DM_ARB_LOCK_EN
  // Lock ownership: taken by a locked grant, released by an unlocked grant to
  // the owner or by the owner dropping req
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_valid <= 1'b0;
      owner_id    <= '0;
    end else begin
      if (owner_valid && !req[owner_id]) begin
        owner_valid <= 1'b0;
      end
      if (win_found) begin
        if (req_lock[win_id]) begin
          owner_valid <= 1'b1;
          owner_id    <= win_id;
        end else if (owner_valid && (win_id == owner_id)) begin
          owner_valid <= 1'b0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: table vectors, directed multi-cycle sequences and a
// randomized run checked against a behavioural model of the arbiter.
module tb_dm_port_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    req_wr_en;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic            force_en;
  logic [1:0]      force_sel;
  logic [DW-1:0]   DM_data_out;
  logic [N-1:0]    gnt;
  logic [DW-1:0]   DM_data_in;
  logic [AW-1:0]   DM_addr;
  logic            DM_write_en;
  logic            rd_valid;
  logic [1:0]      rd_id;
  logic [DW-1:0]   rd_data;
`ifdef DM_ARB_LOCK_EN
  logic [N-1:0]    req_lock = '0;
`endif

  logic [AW-1:0] r_addr [N];
  logic [DW-1:0] r_data [N];
  bit            rq [N];
  bit            wq [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_addr[g*AW +: AW] = r_addr[g];
    assign req_data[g*DW +: DW] = r_data[g];
  end

  dm_port_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_wr_en   (req_wr_en),
    .req_addr    (req_addr),
    .req_data    (req_data),
`ifdef DM_ARB_LOCK_EN
    .req_lock    (req_lock),
`endif
    .force_en    (force_en),
    .force_sel   (force_sel),
    .DM_data_out (DM_data_out),
    .gnt         (gnt),
    .DM_data_in  (DM_data_in),
    .DM_addr     (DM_addr),
    .DM_write_en (DM_write_en),
    .rd_valid    (rd_valid),
    .rd_id       (rd_id),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  // Synchronous data memory attached to the DM port
  logic [DW-1:0] dmem [256] = '{default: '0};
  logic [DW-1:0] dm_q = '0;
  always @(posedge clk) begin
    if (DM_write_en) dmem[DM_addr[7:0]] <= DM_data_in;
    dm_q <= dmem[DM_addr[7:0]];
  end
  assign DM_data_out = dm_q;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  int            m_ptr;
  int            m_last;
  bit            m_pend;
  int            m_pend_id;
  logic [DW-1:0] m_pend_data;
  logic [DW-1:0] m_mem [256] = '{default: '0};
  logic [N-1:0]  e_gnt;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;
  logic          e_we;
  logic          e_rv;
  logic [1:0]    e_rid;
  logic [DW-1:0] e_rdata;

  task automatic model_reset();
    m_ptr = 0; m_last = -1; m_pend = 0; m_pend_id = 0; m_pend_data = '0;
    e_gnt = '0; e_addr = '0; e_din = '0; e_we = 1'b0;
    e_rv = 1'b0; e_rid = '0; e_rdata = '0;
  endtask

  // One clock edge of the arbiter, expressed from the priority rules
  task automatic model_edge();
    int win;
    int idx;
    e_rv = m_pend;
    if (m_pend) begin
      e_rid   = 2'(m_pend_id);
      e_rdata = m_pend_data;
    end
    m_pend = 0;
    win = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (win < 0 && rq[idx] && idx != m_last && (!force_en || idx == int'(force_sel)))
        win = idx;
    end
    if (win >= 0) begin
      e_gnt  = 4'(1 << win);
      e_addr = r_addr[win];
      e_din  = r_data[win];
      e_we   = wq[win];
      if (wq[win]) begin
        m_mem[r_addr[win][7:0]] = r_data[win];
      end else begin
        m_pend      = 1;
        m_pend_id   = win;
        m_pend_data = m_mem[r_addr[win][7:0]];
      end
      if (!force_en) m_ptr = (win + 1) % N;
      m_last = win;
    end else begin
      e_gnt  = '0;
      e_we   = 1'b0;
      m_last = -1;
    end
  endtask

  task automatic check_all();
    chk("gnt",   32'(gnt),         32'(e_gnt));
    chk("we",    32'(DM_write_en), 32'(e_we));
    chk("addr",  32'(DM_addr),     32'(e_addr));
    chk("din",   32'(DM_data_in),  32'(e_din));
    chk("rv",    32'(rd_valid),    32'(e_rv));
    if (e_rv) begin
      chk("rid",   32'(rd_id),   32'(e_rid));
      chk("rdata", 32'(rd_data), 32'(e_rdata));
    end
  endtask

  task automatic set_req(input logic [3:0] r, input logic [3:0] w);
    req = r; req_wr_en = w;
    rq[0] = r[0]; rq[1] = r[1]; rq[2] = r[2]; rq[3] = r[3];
    wq[0] = w[0]; wq[1] = w[1]; wq[2] = w[2]; wq[3] = w[3];
  endtask

  task automatic apply_cycle();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  wr;
    logic        fen;
    logic [1:0]  fsel;
    logic [3:0]  gnt;
    logic [15:0] addr;
    logic        we;
    logic        rv;
    logic [1:0]  rid;
    logic [15:0] rdata;
  } vec_t;

  vec_t tbl [16];

  bit            active [N];
  logic [3:0]    nr;
  logic [3:0]    nw;

  initial begin
    // Rows 0-7: four writers held high; rows 8-11 forced to requester 1;
    // rows 12-15 force released, round-robin continues from the pointer at 0.
    for (int r = 0; r < 8; r++)
      tbl[r] = '{4'b1111, 4'b1111, 1'b0, 2'd0, 4'(1 << (r % 4)), 16'((r % 4) * 16),
                 1'b1, 1'b0, 2'd0, 16'h0};
    tbl[8]  = '{4'b1011, 4'b0000, 1'b1, 2'd1, 4'b0010, 16'h0010, 1'b0, 1'b0, 2'd0, 16'h0};
    tbl[9]  = '{4'b1011, 4'b0000, 1'b1, 2'd1, 4'b0000, 16'h0010, 1'b0, 1'b1, 2'd1, 16'hA0A1};
    tbl[10] = '{4'b1011, 4'b0000, 1'b1, 2'd1, 4'b0010, 16'h0010, 1'b0, 1'b0, 2'd0, 16'h0};
    tbl[11] = '{4'b1011, 4'b0000, 1'b1, 2'd1, 4'b0000, 16'h0010, 1'b0, 1'b1, 2'd1, 16'hA0A1};
    tbl[12] = '{4'b1011, 4'b0000, 1'b0, 2'd1, 4'b0001, 16'h0000, 1'b0, 1'b0, 2'd0, 16'h0};
    tbl[13] = '{4'b1011, 4'b0000, 1'b0, 2'd1, 4'b0010, 16'h0010, 1'b0, 1'b1, 2'd0, 16'hA0A0};
    tbl[14] = '{4'b1011, 4'b0000, 1'b0, 2'd1, 4'b1000, 16'h0030, 1'b0, 1'b1, 2'd1, 16'hA0A1};
    tbl[15] = '{4'b1011, 4'b0000, 1'b0, 2'd1, 4'b0001, 16'h0000, 1'b0, 1'b1, 2'd3, 16'hA0A3};

    rst = 1'b1; force_en = 1'b0; force_sel = '0;
    set_req(4'b0000, 4'b0000);
    for (int i = 0; i < N; i++) begin r_addr[i] = '0; r_data[i] = '0; end
    model_reset();

    // Reset state
    #2;
    check_all();
    chk("rst_rid",   32'(rd_id),   32'h0);
    chk("rst_rdata", 32'(rd_data), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset
    repeat (5) begin
      apply_cycle();
      chk("idle_gnt", 32'(gnt),         32'h0);
      chk("idle_we",  32'(DM_write_en), 32'h0);
      chk("idle_rv",  32'(rd_valid),    32'h0);
    end

    // Single reader at 0x40 held high: grant every other cycle
    r_addr[2] = 16'h0040;
    set_req(4'b0100, 4'b0000);
    for (int c = 1; c <= 8; c++) begin
      apply_cycle();
      chk("single_gnt", 32'(gnt), (c % 2 == 1) ? 32'h4 : 32'h0);
      chk("single_rv",  32'(rd_valid), (c % 2 == 0) ? 32'h1 : 32'h0);
      if (c % 2 == 0) chk("single_rid", 32'(rd_id), 32'h2);
    end
    set_req(4'b0000, 4'b0000);
    repeat (2) apply_cycle();

    // Table vectors
    do_reset();
    for (int i = 0; i < N; i++) begin
      r_addr[i] = 16'(i * 16);
      r_data[i] = 16'hA0A0 + 16'(i);
    end
    for (int r = 0; r < 16; r++) begin
      set_req(tbl[r].req, tbl[r].wr);
      force_en  = tbl[r].fen;
      force_sel = tbl[r].fsel;
      apply_cycle();
      chk($sformatf("tbl%0d_gnt", r),  32'(gnt),         32'(tbl[r].gnt));
      chk($sformatf("tbl%0d_addr", r), 32'(DM_addr),     32'(tbl[r].addr));
      chk($sformatf("tbl%0d_we", r),   32'(DM_write_en), 32'(tbl[r].we));
      chk($sformatf("tbl%0d_rv", r),   32'(rd_valid),    32'(tbl[r].rv));
      if (tbl[r].rv) begin
        chk($sformatf("tbl%0d_rid", r),   32'(rd_id),   32'(tbl[r].rid));
        chk($sformatf("tbl%0d_rdata", r), 32'(rd_data), 32'(tbl[r].rdata));
      end
    end

    // Reset pulsed mid-cycle while a read is on the bus
    set_req(4'b0000, 4'b0000);
    force_en = 1'b0;
    do_reset();
    r_addr[2] = 16'h0040;
    set_req(4'b0100, 4'b0000);
    apply_cycle();
    chk("midrst_pre_gnt",  32'(gnt),     32'h4);
    chk("midrst_pre_addr", 32'(DM_addr), 32'h40);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_gnt",   32'(gnt),         32'h0);
    chk("midrst_addr",  32'(DM_addr),     32'h0);
    chk("midrst_din",   32'(DM_data_in),  32'h0);
    chk("midrst_we",    32'(DM_write_en), 32'h0);
    chk("midrst_rv",    32'(rd_valid),    32'h0);
    chk("midrst_rid",   32'(rd_id),       32'h0);
    chk("midrst_rdata", 32'(rd_data),     32'h0);
    set_req(4'b0000, 4'b0000);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (2) begin
      apply_cycle();
      chk("midrst_after_rv", 32'(rd_valid), 32'h0);
    end

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < N; i++) active[i] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      nr = '0;
      nw = '0;
      for (int i = 0; i < N; i++) begin
        if (m_last == i) active[i] = 0;
        if (!active[i] && $urandom_range(0, 99) < 45) begin
          active[i] = 1;
          wq[i]     = bit'($urandom_range(0, 1));
          r_addr[i] = 16'($urandom_range(0, 7) * 16);
          r_data[i] = 16'($urandom);
        end
        if (active[i]) nr = nr | 4'(1 << i);
        if (wq[i])     nw = nw | 4'(1 << i);
      end
      if ($urandom_range(0, 99) < 6) begin
        force_en  = ~force_en;
        force_sel = 2'($urandom_range(0, 3));
      end
      set_req(nr, nw);
      apply_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
